// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg
//   Shared definitions for the interrupt controller: FSM state encoding,
//   register address map and parameter defaults.
package int_ctrl_pkg;

    localparam int NUM_SRC_DEF     = 5;
    localparam int SYNC_STAGES_DEF = 2;

    // Encoding is architecturally visible through STATUS[9:8].
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_EOI     = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

endpackage

// File: rtl/int_sync_edge.sv
// int_sync_edge
//   Synchronises one asynchronous interrupt line and flags its rising edge.
//   Ports:
//     clk    - system clock
//     reset  - asynchronous active-low reset
//     i_irq  - raw asynchronous interrupt line
//     o_rise - one-cycle rising-edge flag, valid in the clk domain
module int_sync_edge
    import int_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_irq,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_edge;
    logic                   r_armed;
    logic                   w_sync_out;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    // r_fill marks when the synchroniser output holds a sample taken after
    // reset release. r_armed is only set once such a sample reads 0, so a
    // line already high at release never produces an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync  <= '0;
            r_fill  <= '0;
            r_edge  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_sync <= (r_sync << 1) | SYNC_STAGES'(i_irq);
            r_fill <= (r_fill << 1) | SYNC_STAGES'(1'b1);
            r_edge <= w_sync_out;
            if (r_fill[SYNC_STAGES-1] && !w_sync_out) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_rise = w_sync_out & ~r_edge & r_armed;

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl
//   Edge-triggered interrupt controller with PENDING/MASK registers, fixed
//   priority (bit 0 highest) and an IDLE -> REQ -> SERV service handshake.
//   Ports:
//     clk, reset     - clock, asynchronous active-low reset
//     irq_in         - asynchronous interrupt lines (rising edge significant)
//     Ireq, gntInt   - registered request and one-hot grant to the CPU
//     Iack           - CPU acknowledge pulse (honoured only in REQ)
//     stb_i, we_i, addr_i, dat_i - bus request (0 PENDING, 1 MASK, 2 EOI, 3 STATUS)
//     dat_o, ack_o   - bus response; dat_o is zero whenever ack_o is low
//   Bus handshake: an access is accepted on an edge where stb_i=1 and ack_o=0;
//   ack_o is high for the following cycle, writes take effect on that same
//   accepting edge, and read data is captured from pre-edge register state.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = NUM_SRC_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic               Ireq,
    output logic [NUM_SRC-1:0] gntInt,
    input  logic               Iack,
    input  logic               stb_i,
    input  logic               we_i,
    input  logic [1:0]         addr_i,
    input  logic [31:0]        dat_i,
    output logic [31:0]        dat_o,
    output logic               ack_o
);

    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] r_pend;
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] r_gnt;
    logic [NUM_SRC-1:0] w_gnt_nxt;
    logic [NUM_SRC-1:0] w_cand;
    logic [NUM_SRC-1:0] w_pick;
    logic [NUM_SRC-1:0] w_w1c;
    logic [NUM_SRC-1:0] w_iack_clr;
    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_ireq;
    logic               w_ireq_nxt;
    logic               r_ack;
    logic [31:0]        r_dat;
    logic [31:0]        w_rd_data;
    logic               w_acc;
    logic               w_wr;
    logic               w_eoi;
    logic               w_unused_dat;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        int_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .reset  (reset),
            .i_irq  (irq_in[g]),
            .o_rise (w_rise[g])
        );
    end

    // Bus decode: a held strobe is accepted every other cycle.
    assign w_acc = stb_i & ~r_ack;
    assign w_wr  = w_acc & we_i;
    assign w_eoi = w_wr && (addr_i == ADDR_EOI);
    assign w_w1c = (w_wr && (addr_i == ADDR_PENDING)) ? dat_i[NUM_SRC-1:0] : '0;
    assign w_unused_dat = ^dat_i[31:NUM_SRC];

    assign w_iack_clr = ((r_state == ST_REQ) && Iack) ? r_gnt : '0;

    // Lowest set bit of the candidate set is the highest priority.
    assign w_cand = r_pend & r_mask;
    assign w_pick = w_cand & (~w_cand + NUM_SRC'(1));

    // STATUS layout assumes NUM_SRC <= 8 so the grant never reaches bit 8.
    always_comb begin
        w_rd_data = '0;
        case (addr_i)
            ADDR_PENDING: w_rd_data[NUM_SRC-1:0] = r_pend;
            ADDR_MASK:    w_rd_data[NUM_SRC-1:0] = r_mask;
            ADDR_STATUS: begin
                w_rd_data[9:8]         = r_state;
                w_rd_data[NUM_SRC-1:0] = r_gnt;
            end
            default:      w_rd_data = '0;
        endcase
    end

    // Registers and bus response. An edge arriving on the same cycle as a
    // clear (W1C or Iack) wins because it is OR-ed in after the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
            r_mask <= '0;
            r_ack  <= 1'b0;
            r_dat  <= '0;
        end else begin
            r_pend <= (r_pend & ~w_w1c & ~w_iack_clr) | w_rise;
            if (w_wr && (addr_i == ADDR_MASK)) begin
                r_mask <= dat_i[NUM_SRC-1:0];
            end
            r_ack <= w_acc;
            r_dat <= (w_acc && !we_i) ? w_rd_data : '0;
        end
    end

    // FSM state register; grant and request are registered alongside it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_ireq  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ireq  <= w_ireq_nxt;
        end
    end

    // Once granted, the source is held until EOI; masking it in REQ does not
    // withdraw the request.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ireq_nxt  = r_ireq;
        case (r_state)
            ST_IDLE: begin
                if (|w_cand) begin
                    w_state_nxt = ST_REQ;
                    w_gnt_nxt   = w_pick;
                    w_ireq_nxt  = 1'b1;
                end
            end
            ST_REQ: begin
                if (Iack) begin
                    w_state_nxt = ST_SERV;
                    w_ireq_nxt  = 1'b0;
                end
            end
            ST_SERV: begin
                if (w_eoi) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_ireq_nxt  = 1'b0;
            end
        endcase
    end

    assign Ireq   = r_ireq;
    assign gntInt = r_gnt;
    assign ack_o  = r_ack;
    assign dat_o  = r_dat;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl
//   Directed bench for int_ctrl with a behavioural reference model checked
//   on every falling edge, plus literal expectations for each scenario.
`timescale 1ns/1ps
module tb_int_ctrl;

    localparam int N    = 5;
    localparam int SYNC = 2;
    localparam logic [1:0] A_PEND = 2'd0;
    localparam logic [1:0] A_MASK = 2'd1;
    localparam logic [1:0] A_EOI  = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;
    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_SERV = 2;

    logic          clk    = 1'b0;
    logic          reset  = 1'b0;
    logic [N-1:0]  irq_in = '0;
    logic          Ireq;
    logic [N-1:0]  gntInt;
    logic          Iack   = 1'b0;
    logic          stb_i  = 1'b0;
    logic          we_i   = 1'b0;
    logic [1:0]    addr_i = '0;
    logic [31:0]   dat_i  = '0;
    logic [31:0]   dat_o;
    logic          ack_o;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;
    logic [31:0] rd;

    int_ctrl #(.NUM_SRC(N), .SYNC_STAGES(SYNC)) dut (
        .clk    (clk),
        .reset  (reset),
        .irq_in (irq_in),
        .Ireq   (Ireq),
        .gntInt (gntInt),
        .Iack   (Iack),
        .stb_i  (stb_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .dat_i  (dat_i),
        .dat_o  (dat_o),
        .ack_o  (ack_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [N-1:0] m_pend, m_mask, m_gnt;
    int           m_phase;
    logic         m_ireq, m_ack;
    logic [31:0]  m_dat;
    logic [N-1:0] smp_q[$];       // irq_in samples, newest first, post-release only
    logic [N-1:0] mr_rise, mr_cand, mr_clr;
    logic [31:0]  mr_rd;
    bit           mr_acc;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pend = '0; m_mask = '0; m_gnt = '0; m_phase = P_IDLE;
            m_ireq = 1'b0; m_ack = 1'b0; m_dat = '0;
            smp_q.delete();
        end else begin
            // A source becomes pending when a 0 followed by a 1, both sampled
            // after release, has travelled through the synchroniser.
            mr_rise = '0;
            if (smp_q.size() > SYNC) mr_rise = smp_q[SYNC-1] & ~smp_q[SYNC];
            smp_q.push_front(irq_in);
            if (smp_q.size() > 8) void'(smp_q.pop_back());

            mr_acc = stb_i && !m_ack;
            case (addr_i)
                A_PEND:  mr_rd = 32'(m_pend);
                A_MASK:  mr_rd = 32'(m_mask);
                A_STAT:  mr_rd = (32'(m_phase) << 8) | 32'(m_gnt);
                default: mr_rd = '0;
            endcase
            m_dat = (mr_acc && !we_i) ? mr_rd : '0;
            m_ack = mr_acc;

            mr_clr = '0;
            if (mr_acc && we_i && addr_i == A_PEND) mr_clr = dat_i[N-1:0];
            if (m_phase == P_REQ && Iack) mr_clr = mr_clr | m_gnt;
            mr_cand = m_pend & m_mask;

            case (m_phase)
                P_IDLE: if (mr_cand != '0) begin
                    m_phase = P_REQ;
                    m_ireq  = 1'b1;
                    m_gnt   = '0;
                    for (int i = 0; i < N; i++)
                        if (mr_cand[i] && m_gnt == '0) m_gnt[i] = 1'b1;
                end
                P_REQ: if (Iack) begin
                    m_phase = P_SERV;
                    m_ireq  = 1'b0;
                end
                default: if (mr_acc && we_i && addr_i == A_EOI) begin
                    m_phase = P_IDLE;
                    m_gnt   = '0;
                end
            endcase

            if (mr_acc && we_i && addr_i == A_MASK) m_mask = dat_i[N-1:0];
            m_pend = (m_pend & ~mr_clr) | mr_rise;
        end
    end

    always @(negedge clk) begin
        if (reset && cmp_en) begin
            check("cyc_ack_o",  32'(ack_o),  32'(m_ack));
            check("cyc_dat_o",  dat_o,       m_dat);
            check("cyc_Ireq",   32'(Ireq),   32'(m_ireq));
            check("cyc_gntInt", 32'(gntInt), 32'(m_gnt));
        end
    end

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        stb_i = 1'b1; we_i = 1'b1; addr_i = a; dat_i = d;
        tick(1);
        stb_i = 1'b0; we_i = 1'b0; dat_i = '0;
        tick(1);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        stb_i = 1'b1; we_i = 1'b0; addr_i = a;
        tick(1);
        d = dat_o;
        stb_i = 1'b0;
        tick(1);
    endtask

    task automatic iack_pulse();
        Iack = 1'b1;
        tick(1);
        Iack = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        tick(2);
        check("rst_Ireq",   32'(Ireq),   32'h0);
        check("rst_gntInt", 32'(gntInt), 32'h0);
        check("rst_ack_o",  32'(ack_o),  32'h0);
        reset  = 1'b1;
        cmp_en = 1'b1;
        tick(3);
        bus_read(A_PEND, rd);  check("rst_pending", rd, 32'h0);
        bus_read(A_MASK, rd);  check("rst_mask",    rd, 32'h0);
        bus_read(A_STAT, rd);  check("rst_status",  rd, 32'h0);

        // Basic service of source 3
        bus_write(A_MASK, 32'h1F);
        irq_in = 5'b01000;
        tick(3);
        check("basic_no_req_yet", 32'(Ireq), 32'h0);
        bus_read(A_PEND, rd);  check("basic_pending", rd, 32'h08);
        check("basic_Ireq", 32'(Ireq), 32'h1);
        check("basic_gnt",  32'(gntInt), 32'h08);
        irq_in = '0;
        bus_write(A_EOI, 32'h0);
        check("eoi_in_req_ignored", 32'(Ireq), 32'h1);
        iack_pulse();
        check("basic_Ireq_after_iack", 32'(Ireq), 32'h0);
        bus_read(A_PEND, rd);  check("basic_pending_clr", rd, 32'h0);
        bus_read(A_STAT, rd);  check("basic_status_serv", rd, 32'h208);
        iack_pulse();
        bus_read(A_STAT, rd);  check("iack_in_serv_ignored", rd, 32'h208);
        bus_write(A_EOI, 32'h0);
        bus_read(A_STAT, rd);  check("basic_status_idle", rd, 32'h0);

        // Priority between sources 4 and 1, then masking while in REQ
        irq_in = 5'b10010;
        tick(4);
        irq_in = '0;
        check("prio_first", 32'(gntInt), 32'h02);
        iack_pulse();
        bus_write(A_EOI, 32'h0);
        check("prio_second_Ireq", 32'(Ireq), 32'h1);
        check("prio_second_gnt",  32'(gntInt), 32'h10);
        bus_write(A_MASK, 32'h0);
        check("masked_in_req_Ireq", 32'(Ireq), 32'h1);
        check("masked_in_req_gnt",  32'(gntInt), 32'h10);
        iack_pulse();
        bus_write(A_EOI, 32'h0);
        check("masked_done_Ireq", 32'(Ireq), 32'h0);

        // Masked source pends silently until enabled
        irq_in = 5'b00100;
        tick(4);
        irq_in = '0;
        bus_read(A_PEND, rd);  check("mask_pending", rd, 32'h04);
        check("mask_no_Ireq", 32'(Ireq), 32'h0);
        bus_write(A_MASK, 32'h04);
        check("unmask_Ireq", 32'(Ireq), 32'h1);
        check("unmask_gnt",  32'(gntInt), 32'h04);
        bus_read(A_MASK, rd);  check("mask_readback", rd, 32'h04);
        iack_pulse();
        bus_write(A_EOI, 32'h0);
        bus_write(A_MASK, 32'hFFFF_FFFF);
        bus_read(A_MASK, rd);  check("mask_upper_zero", rd, 32'h1F);

        // W1C colliding with an edge on the same bit: the edge wins
        bus_write(A_MASK, 32'h0);
        irq_in = 5'b00001;
        tick(2);
        bus_write(A_PEND, 32'h1);
        irq_in = '0;
        bus_read(A_PEND, rd);  check("w1c_collision", rd, 32'h01);
        bus_write(A_PEND, 32'h1);
        bus_read(A_PEND, rd);  check("w1c_plain", rd, 32'h0);

        // Iack colliding with a new edge on the granted bit
        bus_write(A_MASK, 32'h1F);
        irq_in = 5'b00010;
        tick(4);
        check("iack_coll_gnt", 32'(gntInt), 32'h02);
        irq_in = '0;
        tick(1);
        irq_in = 5'b00010;
        tick(2);
        iack_pulse();
        irq_in = '0;
        check("iack_coll_Ireq", 32'(Ireq), 32'h0);
        bus_read(A_PEND, rd);  check("iack_coll_pending", rd, 32'h02);
        bus_write(A_EOI, 32'h0);
        check("regrant_Ireq", 32'(Ireq), 32'h1);
        check("regrant_gnt",  32'(gntInt), 32'h02);
        iack_pulse();
        bus_write(A_EOI, 32'h0);
        bus_read(A_PEND, rd);  check("regrant_done", rd, 32'h0);

        // Held strobe gives alternating acks; stray Iack in IDLE
        stb_i = 1'b1; we_i = 1'b0; addr_i = A_STAT;
        check("hold_ack0", 32'(ack_o), 32'h0);
        tick(1);  check("hold_ack1", 32'(ack_o), 32'h1);
        tick(1);  check("hold_ack2", 32'(ack_o), 32'h0);
        tick(1);  check("hold_ack3", 32'(ack_o), 32'h1);
        stb_i = 1'b0;
        tick(1);
        iack_pulse();
        check("stray_iack_Ireq", 32'(Ireq), 32'h0);
        bus_read(A_STAT, rd);  check("stray_iack_status", rd, 32'h0);

        // Asynchronous reset in the middle of a request
        irq_in = 5'b10000;
        tick(4);
        check("pre_reset_Ireq", 32'(Ireq), 32'h1);
        #1 reset = 1'b0;
        #1;
        check("async_rst_Ireq", 32'(Ireq),   32'h0);
        check("async_rst_gnt",  32'(gntInt), 32'h0);
        check("async_rst_ack",  32'(ack_o),  32'h0);
        check("async_rst_dat",  dat_o,       32'h0);
        tick(2);
        reset = 1'b1;
        tick(6);
        check("held_high_no_req", 32'(Ireq), 32'h0);
        bus_read(A_PEND, rd);  check("held_high_no_pend", rd, 32'h0);
        bus_read(A_MASK, rd);  check("async_rst_mask",    rd, 32'h0);
        irq_in = '0;
        tick(2);
        irq_in = 5'b10000;
        tick(4);
        irq_in = '0;
        bus_read(A_PEND, rd);  check("post_rst_edge_pend", rd, 32'h10);
        check("post_rst_masked_no_req", 32'(Ireq), 32'h0);

        tick(2);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 5, number of interrupt sources; matches the CPU gntInt width.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth per source.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (reset=0 resets the block).
REQ-005 irq_in  input  NUM_SRC  asynchronous interrupt lines, rising-edge significant.
REQ-006 Ireq  output  1  interrupt request to the CPU.
REQ-007 gntInt  output  NUM_SRC  one-hot grant, the cause bits for the CPU.
REQ-008 Iack  input  1  CPU acknowledge, single-cycle pulse.
REQ-009 stb_i  input  1  bus strobe for register access.
REQ-010 we_i  input  1  bus write enable.
REQ-011 addr_i  input  2  register select: 0 PENDING, 1 MASK, 2 EOI, 3 STATUS.
REQ-012 dat_i  input  32  bus write data.
REQ-013 dat_o  output  32  bus read data.
REQ-014 ack_o  output  1  bus acknowledge.

Function
REQ-015 Each irq_in bit SHALL pass through SYNC_STAGES flops plus one edge flop; a rising edge SHALL set PENDING[i] 3 clocks after the first sampling edge.
REQ-016 PENDING write SHALL be write-1-to-clear; when an edge set and a clear hit the same bit in the same cycle, the set SHALL win.
REQ-017 MASK SHALL be read/write on bits [NUM_SRC-1:0]; bit=1 enables the source; upper bits SHALL read 0.
REQ-018 The candidate set SHALL be PENDING & MASK, with fixed priority: bit 0 highest.
REQ-019 The FSM SHALL have states IDLE, REQ and SERV.
REQ-020 IDLE->REQ SHALL occur on the first clock with a non-zero candidate set; gntInt SHALL latch the one-hot highest-priority candidate on that edge.
REQ-021 In REQ, Ireq SHALL be 1 and gntInt SHALL be held stable; new edges SHALL NOT change gntInt.
REQ-022 In REQ, Iack=1 SHALL clear the granted PENDING bit and move to SERV; a simultaneous new edge on that bit SHALL leave it pending.
REQ-023 Iack outside REQ SHALL be ignored.
REQ-024 In SERV, Ireq SHALL be 0 and gntInt SHALL hold the serviced source; there is no nesting.
REQ-025 Any write to EOI in SERV SHALL return the FSM to IDLE and clear gntInt; an EOI write in other states SHALL be ignored.
REQ-026 If the granted source is masked while in REQ, the request SHALL stand until Iack.
REQ-027 STATUS read SHALL return {state[1:0] at bits 9:8, gntInt at bits 4:0}, with all other bits 0.
REQ-028 Bus timing:
 - ack_o SHALL be 1 exactly one cycle after a cycle with stb_i=1 and ack_o=0.
 - A held stb_i SHALL yield alternating acks.
 - Writes SHALL take effect on the ack edge.
 - dat_o SHALL be valid while ack_o=1 and 0 otherwise.
REQ-029 Ireq and gntInt SHALL be register outputs with no combinational path from bus or irq_in.

Reset
REQ-030 On reset=0, all of the following SHALL clear immediately, including mid-request: state=IDLE, Ireq=0, gntInt=0, PENDING=0, MASK=0, synchronizer and edge flops=0, ack_o=0, dat_o=0.
REQ-031 After reset release, the first edge detected SHALL require a 0->1 transition seen after release; a line already high SHALL NOT trigger.

Structure
REQ-032 A shared package SHALL hold:
 - the state encoding (IDLE=0, REQ=1, SERV=2);
 - the register address constants;
 - the NUM_SRC default.
REQ-033 Synchronizer and edge detection SHALL be one sub-module, int_sync_edge, instantiated once per source.

Verification
REQ-034 Basic service: MASK=0x1F, pulse irq_in[3] -> PENDING=0x08 after 3 clocks, Ireq=1 with gntInt=5'b01000 the next clock, Iack -> PENDING=0, Ireq=0, STATUS=0x208; EOI write -> STATUS=0x000.
REQ-035 Priority: MASK=0x1F, edges on bits 4 and 1 in the same cycle -> gntInt=5'b00010 first; after Iack and EOI, gntInt=5'b10000.
REQ-036 Masking: MASK=0x00, edge on bit 2 -> PENDING=0x04, Ireq stays 0; write MASK=0x04 -> Ireq=1, gntInt=5'b00100.
REQ-037 Collisions:
 - W1C of PENDING bit 0 in the same cycle as an edge on bit 0 -> PENDING[0]=1.
 - Iack and a new edge on the granted bit in the same cycle -> bit remains pending and is re-granted after EOI.
REQ-038 Reset mid-REQ: drive reset=0 asynchronously between clock edges while Ireq=1 -> Ireq=0, gntInt=0, MASK=0 before the next edge; irq_in held high through release -> no request.
REQ-039 Bus/Iack protocol:
 - stb_i held for 4 cycles -> ack_o pattern 0,1,0,1.
 - Stray Iack in IDLE -> no state change.
